// File: rtl/bridge_pkg.sv
// Shared types for the Harvard-to-Avalon bridge: FSM state encoding and address helpers.
package bridge_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StData   = 3'd3,
        StCommit = 3'd4,
        StHalt   = 3'd5
    } bridge_state_e;

    localparam logic [3:0] ByteEnAll = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/harvard_avalon_bridge.sv
// Serialises the fetch and data ports of a Harvard CPU onto one Avalon-MM master.
// Bus addresses and write data are sampled on the clock edge that starts each access.
module harvard_avalon_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    input  logic        cpu_active,
    output logic        cpu_clk_enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        bus_error
);

    localparam int unsigned CntW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_TIMEOUT - 1);

    bridge_state_e state_q, state_d;

    logic            op_write_q, op_write_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]     avm_address_q, avm_address_d;
    logic [31:0]     avm_writedata_q, avm_writedata_d;
    logic            avm_read_q, avm_read_d;
    logic            avm_write_q, avm_write_d;
    logic [31:0]     instr_rdata_q, instr_rdata_d;
    logic [31:0]     data_rdata_q, data_rdata_d;
    logic            bus_error_q, bus_error_d;

    logic in_access;
    logic timeout;
    logic enter_fetch;
    logic enter_data;

    assign in_access = (state_q == StFetch) || (state_q == StData);
    assign timeout   = (WAIT_TIMEOUT != 0) && in_access && avm_waitrequest &&
                       (wait_cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch: begin
                if (!avm_waitrequest) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StHalt;
                end
            end
            StDecode: state_d = (cpu_data_write || cpu_data_read) ? StData : StCommit;
            StData: begin
                if (!avm_waitrequest) begin
                    state_d = StCommit;
                end else if (timeout) begin
                    state_d = StHalt;
                end
            end
            StCommit: state_d = cpu_active ? StFetch : StHalt;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_clk_enable = (state_q == StCommit);

        enter_fetch = (state_d == StFetch) && (state_q != StFetch);
        enter_data  = (state_d == StData) && (state_q != StData);

        // Write wins over read; the decision is frozen for the whole data access.
        op_write_d  = (state_q == StDecode) ? cpu_data_write : op_write_q;

        avm_read_d  = (state_d == StFetch) || ((state_d == StData) && !op_write_d);
        avm_write_d = (state_d == StData) && op_write_d;

        avm_address_d = avm_address_q;
        if (enter_fetch) begin
            avm_address_d = word_align(cpu_instr_address);
        end else if (enter_data) begin
            avm_address_d = word_align(cpu_data_address);
        end

        avm_writedata_d = enter_data ? cpu_data_writedata : avm_writedata_q;

        wait_cnt_d = wait_cnt_q;
        if (enter_fetch || enter_data) begin
            wait_cnt_d = '0;
        end else if ((WAIT_TIMEOUT != 0) && in_access && avm_waitrequest) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end

        instr_rdata_d = ((state_q == StFetch) && !avm_waitrequest) ? avm_readdata
                                                                    : instr_rdata_q;
        data_rdata_d  = ((state_q == StData) && !op_write_q && !avm_waitrequest)
                        ? avm_readdata : data_rdata_q;

        bus_error_d = bus_error_q | timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_write_q      <= 1'b0;
            wait_cnt_q      <= '0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            instr_rdata_q   <= '0;
            data_rdata_q    <= '0;
            bus_error_q     <= 1'b0;
        end else begin
            op_write_q      <= op_write_d;
            wait_cnt_q      <= wait_cnt_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            instr_rdata_q   <= instr_rdata_d;
            data_rdata_q    <= data_rdata_d;
            bus_error_q     <= bus_error_d;
        end
    end

    assign avm_address        = avm_address_q;
    assign avm_writedata      = avm_writedata_q;
    assign avm_read           = avm_read_q;
    assign avm_write          = avm_write_q;
    assign avm_byteenable     = ByteEnAll;
    assign cpu_instr_readdata = instr_rdata_q;
    assign cpu_data_readdata  = data_rdata_q;
    assign bus_error          = bus_error_q;

endmodule

// File: tb/tb_harvard_avalon_bridge.sv
// Self-checking bench: instruction-level reference model drives a timed Avalon slave
// and predicts every bus cycle, commit strobe and latched read word.
module tb_harvard_avalon_bridge;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] iword;
        logic        dread;
        logic        dwrite;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          fwait;
        int          dwait;
        logic        active;
        int          exp_cycles;
    } instr_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        ce;
        logic        wreq;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } cyc_t;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic        cpu_active;
    logic        cpu_clk_enable;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        bus_error;

    logic [31:0] nt_instr_readdata;
    logic [31:0] nt_data_readdata;
    logic        nt_clk_enable;
    logic [31:0] nt_avm_address;
    logic        nt_avm_read;
    logic        nt_avm_write;
    logic [31:0] nt_avm_writedata;
    logic [3:0]  nt_avm_byteenable;
    logic        nt_bus_error;

    int          checks;
    int          errors;
    logic [31:0] exp_drd;

    harvard_avalon_bridge #(.WAIT_TIMEOUT(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_instr_readdata (cpu_instr_readdata),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (cpu_data_readdata),
        .cpu_active         (cpu_active),
        .cpu_clk_enable     (cpu_clk_enable),
        .avm_address        (avm_address),
        .avm_read           (avm_read),
        .avm_write          (avm_write),
        .avm_writedata      (avm_writedata),
        .avm_byteenable     (avm_byteenable),
        .avm_readdata       (avm_readdata),
        .avm_waitrequest    (avm_waitrequest),
        .bus_error          (bus_error)
    );

    // Unlimited-wait instance shares all inputs; only checked in the stuck-bus sequence.
    harvard_avalon_bridge dut_nt (
        .clk                (clk),
        .reset              (reset),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_instr_readdata (nt_instr_readdata),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (nt_data_readdata),
        .cpu_active         (cpu_active),
        .cpu_clk_enable     (nt_clk_enable),
        .avm_address        (nt_avm_address),
        .avm_read           (nt_avm_read),
        .avm_write          (nt_avm_write),
        .avm_writedata      (nt_avm_writedata),
        .avm_byteenable     (nt_avm_byteenable),
        .avm_readdata       (avm_readdata),
        .avm_waitrequest    (avm_waitrequest),
        .bus_error          (nt_bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] iword,
                                  input logic rd, input logic wr, input logic [31:0] daddr,
                                  input logic [31:0] wdata, input logic [31:0] rword,
                                  input int fw, input int dw, input logic act,
                                  input int cyc);
        instr_t t;
        t.pc = pc; t.iword = iword; t.dread = rd; t.dwrite = wr; t.daddr = daddr;
        t.wdata = wdata; t.rword = rword; t.fwait = fw; t.dwait = dw; t.active = act;
        t.exp_cycles = cyc;
        return t;
    endfunction

    function automatic instr_t rand_instr(input logic act);
        int kind;
        logic rd;
        logic wr;
        int fw;
        int dw;
        kind = $urandom_range(0, 3);
        rd   = (kind == 1) || (kind == 3);
        wr   = (kind >= 2);
        fw   = $urandom_range(0, 3);
        dw   = $urandom_range(0, 3);
        return mk($urandom, $urandom, rd, wr, $urandom, $urandom, $urandom, fw, dw, act,
                  3 + fw + ((rd || wr) ? 1 + dw : 0));
    endfunction

    task automatic apply_inputs(input instr_t t);
        cpu_instr_address  = t.pc;
        cpu_data_address   = t.daddr;
        cpu_data_read      = t.dread;
        cpu_data_write     = t.dwrite;
        cpu_data_writedata = t.wdata;
    endtask

    task automatic do_reset(input instr_t first);
        reset           = 1'b1;
        avm_waitrequest = 1'b1;
        avm_readdata    = $urandom;
        cpu_active      = 1'b1;
        apply_inputs(first);
        tick();
        tick();
        chk("rst_read",   32'(avm_read), 32'd0);
        chk("rst_write",  32'(avm_write), 32'd0);
        chk("rst_addr",   avm_address, 32'd0);
        chk("rst_wdata",  avm_writedata, 32'd0);
        chk("rst_be",     32'(avm_byteenable), 32'hF);
        chk("rst_ce",     32'(cpu_clk_enable), 32'd0);
        chk("rst_ird",    cpu_instr_readdata, 32'd0);
        chk("rst_drd",    cpu_data_readdata, 32'd0);
        chk("rst_buserr", 32'(bus_error), 32'd0);
        reset   = 1'b0;
        exp_drd = 32'd0;
        chk("idle_read", 32'(avm_read), 32'd0);
        chk("idle_ce",   32'(cpu_clk_enable), 32'd0);
        tick();
    endtask

    // Entry: just after the edge that moved the bridge into FETCH for cur.
    task automatic run_instr(input instr_t cur, input instr_t nxt);
        cyc_t        s[$];
        cyc_t        c;
        logic [31:0] prev_drd;
        int          ce_at;
        logic        has_data;
        has_data = cur.dread || cur.dwrite;
        for (int j = 0; j <= cur.fwait; j++) begin
            c = '0;
            c.rd    = 1'b1;
            c.wreq  = (j < cur.fwait);
            c.addr  = cur.pc & 32'hFFFF_FFFC;
            c.rdata = (j < cur.fwait) ? $urandom : cur.iword;
            s.push_back(c);
        end
        c = '0;
        c.wreq  = 1'($urandom);
        c.rdata = $urandom;
        s.push_back(c);
        if (has_data) begin
            for (int j = 0; j <= cur.dwait; j++) begin
                c = '0;
                c.rd    = !cur.dwrite;
                c.wr    = cur.dwrite;
                c.wreq  = (j < cur.dwait);
                c.addr  = cur.daddr & 32'hFFFF_FFFC;
                c.wdata = cur.wdata;
                c.rdata = ((j == cur.dwait) && !cur.dwrite) ? cur.rword : $urandom;
                s.push_back(c);
            end
        end
        c = '0;
        c.ce    = 1'b1;
        c.wreq  = 1'($urandom);
        c.rdata = $urandom;
        s.push_back(c);

        prev_drd = exp_drd;
        if (cur.dread && !cur.dwrite) exp_drd = cur.rword;
        ce_at = -1;

        for (int k = 0; k < s.size(); k++) begin
            avm_waitrequest = s[k].wreq;
            avm_readdata    = s[k].rdata;
            cpu_active      = s[k].ce ? cur.active : 1'($urandom);
            if (cpu_clk_enable && ce_at < 0) ce_at = k;
            chk("avm_read",  32'(avm_read), 32'(s[k].rd));
            chk("avm_write", 32'(avm_write), 32'(s[k].wr));
            chk("clk_en",    32'(cpu_clk_enable), 32'(s[k].ce));
            if (s[k].rd || s[k].wr) chk("avm_addr", avm_address, s[k].addr);
            if (s[k].wr) begin
                chk("avm_wdata", avm_writedata, s[k].wdata);
                chk("avm_be",    32'(avm_byteenable), 32'hF);
            end
            if (k == cur.fwait + 1) begin
                chk("decode_ird", cpu_instr_readdata, cur.iword);
                chk("decode_drd", cpu_data_readdata, prev_drd);
            end
            if (s[k].ce) begin
                chk("commit_ird", cpu_instr_readdata, cur.iword);
                chk("commit_drd", cpu_data_readdata, exp_drd);
                apply_inputs(nxt);
            end
            tick();
        end
        chk("latency", 32'(ce_at + 1), 32'(cur.exp_cycles));

        if (!cur.active) begin
            for (int k = 0; k < 20; k++) begin
                avm_waitrequest = 1'($urandom);
                avm_readdata    = $urandom;
                cpu_active      = 1'($urandom);
                chk("halt_read",  32'(avm_read), 32'd0);
                chk("halt_write", 32'(avm_write), 32'd0);
                chk("halt_ce",    32'(cpu_clk_enable), 32'd0);
                tick();
            end
        end
    endtask

    instr_t dir[5];
    instr_t rq[$];
    instr_t tmo;
    instr_t ld;

    initial begin
        checks             = 0;
        errors             = 0;
        exp_drd            = 32'd0;
        reset              = 1'b1;
        cpu_active         = 1'b1;
        avm_waitrequest    = 1'b1;
        avm_readdata       = 32'd0;
        cpu_instr_address  = 32'd0;
        cpu_data_address   = 32'd0;
        cpu_data_read      = 1'b0;
        cpu_data_write     = 1'b0;
        cpu_data_writedata = 32'd0;

        //        pc            iword         rd    wr    daddr         wdata
        //        rword         fw dw act   cycles
        dir[0] = mk(32'hBFC0_0000, 32'h0085_1021, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000,
                    32'h0000_0000, 0, 0, 1'b1, 3);
        dir[1] = mk(32'hBFC0_0004, 32'h8C82_0006, 1'b1, 1'b0, 32'h0000_1006, 32'h0000_0000,
                    32'hDEAD_BEEF, 0, 2, 1'b1, 6);
        dir[2] = mk(32'hBFC0_0008, 32'hAC85_0000, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678,
                    32'h0000_0000, 0, 0, 1'b1, 4);
        dir[3] = mk(32'hBFC0_000C, 32'hAC86_0003, 1'b1, 1'b1, 32'h0000_3003, 32'hCAFE_F00D,
                    32'h5555_5555, 1, 1, 1'b1, 6);
        dir[4] = mk(32'hBFC0_0010, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000,
                    32'h0000_0000, 3, 0, 1'b0, 6);

        do_reset(dir[0]);
        for (int i = 0; i < 5; i++) run_instr(dir[i], (i < 4) ? dir[i + 1] : dir[0]);

        for (int i = 0; i < 30; i++) rq.push_back(rand_instr(i != 29));
        do_reset(rq[0]);
        for (int i = 0; i < 30; i++) run_instr(rq[i], (i < 29) ? rq[i + 1] : rq[0]);

        // Stuck waitrequest: limited instance gives up after 4 cycles, unlimited keeps waiting.
        tmo = mk(32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1, 3);
        do_reset(tmo);
        for (int k = 0; k < 10; k++) begin
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom;
            chk("tmo_read",   32'(avm_read), (k < 4) ? 32'd1 : 32'd0);
            chk("tmo_buserr", 32'(bus_error), (k >= 4) ? 32'd1 : 32'd0);
            chk("nt_read",    32'(nt_avm_read), 32'd1);
            chk("nt_buserr",  32'(nt_bus_error), 32'd0);
            tick();
        end

        // Reset during a stalled data read: strobes drop and the returning word is discarded.
        ld = mk(32'h0000_0400, 32'h8C00_0808, 1'b1, 1'b0, 32'h0000_0808, 32'h0,
                32'h1111_2222, 0, 5, 1'b1, 0);
        do_reset(ld);
        avm_waitrequest = 1'b0;
        avm_readdata    = ld.iword;
        tick();
        avm_waitrequest = 1'b0;
        avm_readdata    = $urandom;
        tick();
        avm_waitrequest = 1'b1;
        chk("mid_read", 32'(avm_read), 32'd1);
        chk("mid_addr", avm_address, 32'h0000_0808);
        tick();
        chk("mid_read2", 32'(avm_read), 32'd1);
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'hBAD0_BAD0;
        reset           = 1'b1;
        tick();
        chk("mrst_read",  32'(avm_read), 32'd0);
        chk("mrst_write", 32'(avm_write), 32'd0);
        chk("mrst_drd",   cpu_data_readdata, 32'd0);
        chk("mrst_ird",   cpu_instr_readdata, 32'd0);
        reset           = 1'b0;
        avm_waitrequest = 1'b1;
        chk("mrst_idle_read", 32'(avm_read), 32'd0);
        tick();
        chk("refetch_read", 32'(avm_read), 32'd1);
        chk("refetch_addr", avm_address, 32'h0000_0400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/harvard_avalon_bridge.md
HARVARD_AVALON_BRIDGE -- requirements
Module: harvard_avalon_bridge

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 0, meaning max waitrequest-high cycles per access (0 = unlimited).
REQ-002 SHALL have clock clk; reset reset, synchronous, active-high.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 cpu_instr_address  input  32  CPU PC.
REQ-006 cpu_instr_readdata  output  32  latched instruction to CPU.
REQ-007 cpu_data_address  input  32  CPU load/store address.
REQ-008 cpu_data_read / cpu_data_write  input  1 each  CPU data strobes.
REQ-009 cpu_data_writedata  input  32  store word from CPU.
REQ-010 cpu_data_readdata  output  32  latched load word to CPU.
REQ-011 cpu_active  input  1  CPU running flag.
REQ-012 cpu_clk_enable  output  1  single-cycle CPU commit strobe.
REQ-013 avm_address  output  32; avm_read, avm_write  output  1; avm_writedata  output  32; avm_byteenable  output  4.
REQ-014 avm_readdata  input  32; avm_waitrequest  input  1.
REQ-015 bus_error  output  1  sticky timeout flag.

Function
REQ-016 SHALL serialise fetch and data access of the Harvard CPU onto one Avalon-MM master port; states IDLE, FETCH, DECODE, DATA, COMMIT, HALT.
REQ-017 IDLE -> FETCH on first cycle after reset deasserts.
REQ-018 FETCH: avm_read=1, avm_address={cpu_instr_address[31:2],2'b00}; on cycle with avm_waitrequest=0, latch avm_readdata into cpu_instr_readdata, drop avm_read, go DECODE.
REQ-019 DECODE: one cycle, no bus activity; if cpu_data_write -> DATA(write), else if cpu_data_read -> DATA(read), else -> COMMIT.
REQ-020 cpu_data_read and cpu_data_write both high: write SHALL take priority, read ignored.
REQ-021 DATA: avm_address={cpu_data_address[31:2],2'b00}, avm_byteenable=4'b1111, avm_writedata=cpu_data_writedata; complete when avm_waitrequest=0; read latches avm_readdata into cpu_data_readdata; then COMMIT.
REQ-022 avm_address, avm_read, avm_write, avm_writedata SHALL be registered and held stable while avm_waitrequest=1.
REQ-023 avm_read and avm_write SHALL never be high in the same cycle.
REQ-024 COMMIT: cpu_clk_enable=1 for exactly one cycle; next state FETCH if cpu_active=1 that cycle, else HALT.
REQ-025 cpu_clk_enable SHALL be 0 in every state except COMMIT.
REQ-026 HALT: no bus activity, cpu_clk_enable=0; exit only by reset.
REQ-027 Minimum latency per instruction (zero wait): FETCH 1 + DECODE 1 + COMMIT 1 = 3 cycles; +1 with data access; each waitrequest cycle adds 1.
REQ-028 WAIT_TIMEOUT>0: wait counter resets at access start; when it reaches WAIT_TIMEOUT with waitrequest still 1, drop strobes, set bus_error=1, go HALT.
REQ-029 cpu_instr_readdata and cpu_data_readdata SHALL hold value outside their latch cycles.

Reset
REQ-030 On reset: state IDLE; avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=4'b1111, cpu_clk_enable=0, cpu_instr_readdata=0, cpu_data_readdata=0, bus_error=0, wait counter=0.
REQ-031 Reset mid-access SHALL drop strobes next edge; in-flight readdata SHALL be discarded.

Structure
REQ-032 State enum and IDLE/FETCH/DECODE/DATA/COMMIT/HALT encodings SHALL live in shared package bridge_pkg.
REQ-033 Single module, no sub-module; wait counter width = $clog2(WAIT_TIMEOUT+1), minimum 1.

Verification
REQ-034 Zero-wait ALU instr 0x00851021 at PC 0xBFC00000 -> avm_read one cycle at 0xBFC00000, cpu_clk_enable high 3rd cycle, no data access.
REQ-035 Load, cpu_data_address=0x00001006, memory word 0xDEADBEEF, 2 wait cycles -> avm_address 0x00001004 held 3 cycles, cpu_data_readdata=0xDEADBEEF at COMMIT.
REQ-036 Store 0x12345678 to 0x00002000 -> avm_write one cycle, avm_writedata=0x12345678, byteenable 4'b1111, avm_read never high.
REQ-037 cpu_data_read=cpu_data_write=1 -> only avm_write asserted.
REQ-038 cpu_active=0 during COMMIT -> HALT, no further avm_read for 20 cycles; WAIT_TIMEOUT=4 with waitrequest stuck -> bus_error=1 after 4 cycles.
REQ-039 Reset asserted during DATA with waitrequest=1 -> strobes 0 next cycle, FETCH restarts after reset release.
